// File: rtl/ps2_keyboard_tx.sv
// ps2_keyboard_tx
// Device-side PS/2 keyboard transmitter. Scancode bytes are queued in a small
// FIFO and each one is sent as an 11-bit PS/2 frame: a start bit, d0..d7 LSB
// first, odd parity, and a stop bit. ps2_clk and ps2_data are push-pull outputs.
// There is no host inhibit or host-to-device command path.
//
// Ports
//   clk        system clock
//   resetn     synchronous, active-high reset (despite the name)
//   wr_en      push wr_data into the FIFO this cycle
//   wr_data    scancode byte to send
//   full       FIFO full; a push while full is dropped
//   overflow   one-cycle pulse, registered, the cycle after a push is dropped
//   busy       frame or gap in progress, or FIFO not empty
//   frame_done one-cycle pulse when the stop-bit low phase ends
//   ps2_clk    PS/2 clock line, idle high
//   ps2_data   PS/2 data line, idle high
module ps2_keyboard_tx #(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 100,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       frame_done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } state_t;

    // ---------------- FIFO ----------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        empty;
    logic        push;
    logic        pop;
    logic [7:0]  rd_data;
    logic        overflow_reg;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // A push while full is dropped even if a pop frees a slot this same cycle.
    assign push    = wr_en && !full;
    // Read is combinational so the byte is available in the same cycle the
    // FSM pops it; the pop uses registered pointers, so there is no bypass of
    // a byte written this cycle.
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= wr_en && full;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // ---------------- Frame FSM ----------------
    state_t      state_reg,      state_next;
    logic [15:0] cnt_reg,        cnt_next;
    logic [3:0]  bit_idx_reg,    bit_idx_next;
    logic [10:0] sr_reg,         sr_next;
    logic        ps2_clk_reg,    ps2_clk_next;
    logic        ps2_data_reg,   ps2_data_next;
    logic        frame_done_reg, frame_done_next;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            sr_reg         <= '1;
            ps2_clk_reg    <= 1'b1;
            ps2_data_reg   <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            sr_reg         <= sr_next;
            ps2_clk_reg    <= ps2_clk_next;
            ps2_data_reg   <= ps2_data_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_idx_next    = bit_idx_reg;
        sr_next         = sr_reg;
        ps2_clk_next    = ps2_clk_reg;
        ps2_data_next   = ps2_data_reg;
        frame_done_next = 1'b0;
        pop             = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                ps2_clk_next  = 1'b1;
                ps2_data_next = 1'b1;
                if (!empty) begin
                    pop           = 1'b1;
                    // {stop, odd parity, data, start}
                    sr_next       = {1'b1, ~^rd_data, rd_data, 1'b0};
                    bit_idx_next  = 4'd0;
                    cnt_next      = DIV_LOAD;
                    state_next    = ST_HIGH;
                    ps2_data_next = 1'b0;    // start bit
                end
            end
            ST_HIGH: begin
                // Data is already valid from HIGH entry; holding sr[0] keeps
                // it stable for the whole high phase.
                ps2_clk_next  = 1'b1;
                ps2_data_next = sr_reg[0];
                if (cnt_reg == 16'd0) begin
                    ps2_clk_next = 1'b0;
                    cnt_next     = DIV_LOAD;
                    state_next   = ST_LOW;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            ST_LOW: begin
                if (cnt_reg == 16'd0) begin
                    ps2_clk_next = 1'b1;
                    if (bit_idx_reg == 4'd10) begin
                        frame_done_next = 1'b1;
                        ps2_data_next   = 1'b1;
                        cnt_next        = GAP_LOAD;
                        state_next      = ST_GAP;
                    end else begin
                        sr_next       = {1'b0, sr_reg[10:1]};
                        ps2_data_next = sr_reg[1];
                        bit_idx_next  = bit_idx_reg + 4'd1;
                        cnt_next      = DIV_LOAD;
                        state_next    = ST_HIGH;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            ST_GAP: begin
                ps2_clk_next  = 1'b1;
                ps2_data_next = 1'b1;
                if (cnt_reg == 16'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ps2_clk    = ps2_clk_reg;
    assign ps2_data   = ps2_data_reg;
    assign frame_done = frame_done_reg;
    assign overflow   = overflow_reg;
    assign busy       = (state_reg != ST_IDLE) || !empty;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// tb_ps2_keyboard_tx
// Drives ps2_keyboard_tx with directed and random scancode pushes. A line-level
// receiver decodes frames from ps2_clk falling edges; a byte-queue model tracks
// accepted pushes and frame starts to predict full/overflow/busy, frame start
// times and frame_done timing.
module tb_ps2_keyboard_tx;

    localparam int CD    = 4;
    localparam int GAP   = 6;
    localparam int DEPTH = 8;
    localparam int HALF_PHASES = 22 * CD;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       overflow;
    logic       busy;
    logic       frame_done;
    logic       ps2_clk;
    logic       ps2_data;

    ps2_keyboard_tx #(
        .CLK_DIV    (CD),
        .GAP_CYCLES (GAP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .overflow   (overflow),
        .busy       (busy),
        .frame_done (frame_done),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    // Model / receiver state
    logic [7:0]  exp_q[$];
    int          accepted;
    int          started;
    int          frames;
    int          bit_cnt;
    int          frame_edges;
    int          last_start;
    logic        in_frame;
    logic        started_any;
    logic        expect_start;
    logic        prev_clk;
    logic        prev_data;
    logic [10:0] fbits;

    task automatic chk(input string tag, input int got, input int exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        accepted     = 0;
        started      = 0;
        bit_cnt      = 0;
        frame_edges  = 0;
        last_start   = 0;
        in_frame     = 1'b0;
        started_any  = 1'b0;
        expect_start = 1'b0;
        prev_clk     = ps2_clk;
        prev_data    = ps2_data;
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b1;
        wr_en  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        resetn = 1'b0;
        cyc += n;
        clear_model();
        chk("rst_ps2_clk",    int'(ps2_clk),    1);
        chk("rst_ps2_data",   int'(ps2_data),   1);
        chk("rst_busy",       int'(busy),       0);
        chk("rst_full",       int'(full),       0);
        chk("rst_overflow",   int'(overflow),   0);
        chk("rst_frame_done", int'(frame_done), 0);
    endtask

    // One clock cycle: optionally push, then observe the lines and predict.
    task automatic step(input logic we, input logic [7:0] d);
        int         occ;
        logic       acc;
        logic       started_now;
        logic       fd_exp;
        logic       idle_now;
        logic [7:0] b;
        logic [7:0] e;

        occ = accepted - started;
        chk("full", int'(full), int'(occ == DEPTH));
        acc     = we && (occ < DEPTH);
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        cyc++;

        if (acc) begin
            exp_q.push_back(d);
            accepted++;
        end
        chk("overflow", int'(overflow), int'(we && !acc));

        // Frame start: data drops to the start bit while the clock is high.
        started_now = 1'b0;
        if (!in_frame && ps2_clk && prev_data && !ps2_data) begin
            started_now = 1'b1;
            in_frame    = 1'b1;
            bit_cnt     = 0;
            frame_edges = 0;
            started++;
            last_start  = cyc;
            started_any = 1'b1;
        end
        if (started_now || expect_start)
            chk("start_time", int'(started_now), int'(expect_start));

        if (!prev_clk && !ps2_clk)
            chk("data_hold_low", int'(ps2_data), int'(prev_data));

        if (prev_clk && !ps2_clk) begin
            if (!in_frame) begin
                chk("stray_edge", 1, 0);
            end else begin
                fbits[bit_cnt] = ps2_data;
                bit_cnt++;
                frame_edges++;
                if (bit_cnt == 11) begin
                    b = fbits[8:1];
                    chk("start_bit", int'(fbits[0]), 0);
                    chk("stop_bit",  int'(fbits[10]), 1);
                    chk("parity",    int'(fbits[9]), int'(($countones(b) % 2) == 0));
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", int'(b), int'(e));
                    end
                    frames++;
                    $display("frame %0d: received %02h line bits %b (cycle %0d)", frames, b, fbits, cyc);
                    in_frame = 1'b0;
                end
            end
        end

        fd_exp = started_any && (cyc == last_start + HALF_PHASES);
        if (fd_exp || frame_done)
            chk("frame_done", int'(frame_done), int'(fd_exp));
        if (fd_exp)
            chk("edges_per_frame", frame_edges, 11);

        occ      = accepted - started;
        idle_now = !started_any || (cyc >= last_start + HALF_PHASES + GAP);
        chk("busy", int'(busy), int'(!idle_now || occ > 0));
        expect_start = idle_now && (occ > 0);

        prev_clk  = ps2_clk;
        prev_data = ps2_data;
    endtask

    task automatic wait_start(input int max_cycles);
        int n = 0;
        while (!in_frame && n < max_cycles) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk("wait_start", int'(in_frame), 1);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((busy || exp_q.size() > 0) && n < max_cycles) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk("drain_busy", int'(busy), 0);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        int ovf_seen;
        int n;
        frames = 0;
        do_reset(3);

        // Idle hold: lines high, no edges, not busy.
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 8'h00);
            chk("idle_clk",  int'(ps2_clk),  1);
            chk("idle_data", int'(ps2_data), 1);
        end

        // Single 0x1C frame.
        step(1'b1, 8'h1C);
        wait_start(10);
        drain(400);

        // Back-to-back F0 1C.
        step(1'b1, 8'hF0);
        step(1'b1, 8'h1C);
        drain(600);

        // Nine consecutive pushes while idle: first is popped, none dropped.
        ovf_seen = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 8'($urandom));
            ovf_seen += int'(overflow);
        end
        chk("idle_burst_overflow", ovf_seen, 0);
        drain(2000);

        // Nine pushes mid-frame: full after eight, ninth dropped.
        step(1'b1, 8'($urandom));
        wait_start(10);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 8'($urandom));
            if (i == 7) chk("full_after_8", int'(full), 1);
            if (i == 8) chk("overflow_9th", int'(overflow), 1);
        end
        drain(2000);

        // Parity corners.
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        drain(600);

        // Random traffic, fast enough to fill the FIFO at times.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 29) == 0, 8'($urandom));
        end
        drain(2000);

        // Reset during the LOW phase of bit 5.
        step(1'b1, 8'($urandom));
        step(1'b1, 8'($urandom));
        step(1'b1, 8'($urandom));
        wait_start(10);
        n = 0;
        while (in_frame && bit_cnt < 6 && n < 200) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk("reach_bit5", bit_cnt, 6);
        step(1'b0, 8'h00);
        chk("bit5_low", int'(ps2_clk), 0);
        do_reset(1);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 8'h00);
            chk("post_rst_clk",  int'(ps2_clk),  1);
            chk("post_rst_data", int'(ps2_data), 1);
        end

        // Recovery after reset.
        step(1'b1, 8'h5A);
        drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
